// File: rtl/ads869x_pkg.sv
// ads869x_pkg: frame widths, opcodes and FSM encoding shared by the ADS869x SPI emulator.
package ads869x_pkg;
   localparam int FRAME_BITS = 32;
   localparam int DATA_BITS = 18;
   localparam int HWORD_BITS = 16;
   localparam logic [6:0] OP_NOP = 7'b0000000;
   localparam logic [6:0] OP_CLEAR = 7'b1100000;
   localparam logic [6:0] OP_READ = 7'b1100100;
   localparam logic [6:0] OP_WRITE = 7'b1101000;
   localparam logic [6:0] OP_SET = 7'b1101100;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DECODE, ST_CONVERTING} state_t;
endpackage

// File: rtl/ads869x_if.sv
// ads869x_if: host link (SCLK/CONV/SDI/SDO/RVS), sample feed and register/frame status.
interface ads869x_if;
   import ads869x_pkg::*;
   logic sclk, conv, sdi, sdo, rvs;
   logic [DATA_BITS-1:0] sample_in;
   logic reg_wr_valid;
   logic [8:0] reg_wr_addr;
   logic [HWORD_BITS-1:0] reg_wr_data;
   logic frame_done, frame_error, protocol_err;
   modport master (output sclk, conv, sdi, sample_in,
                   input sdo, rvs, reg_wr_valid, reg_wr_addr, reg_wr_data, frame_done, frame_error, protocol_err);
   modport slave (input sclk, conv, sdi, sample_in,
                  output sdo, rvs, reg_wr_valid, reg_wr_addr, reg_wr_data, frame_done, frame_error, protocol_err);
endinterface

// File: rtl/ads869x_sync_edge.sv
// ads869x_sync_edge: synchronizer chain with a one-cycle change pulse; rise = chg_o & q_o, fall = chg_o & ~q_o.
module ads869x_sync_edge #(parameter int STAGES = 2) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o,
   output logic chg_o
);
   logic [STAGES-1:0] sync_q;
   logic prev_q;
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end
   assign q_o = sync_q[STAGES-1];
   assign chg_o = q_o ^ prev_q;
endmodule

// File: rtl/ads869x_spi_emulator.sv
// ads869x_spi_emulator: device side of the ADS869x SPI link with halfword register file and timed conversion.
// Define ADS869X_EMU_RAMP_EN to let register 0 bit0 select an internal 18-bit ramp as the sample source.
module ads869x_spi_emulator
   import ads869x_pkg::*;
#(
   parameter int CLOCK_FREQ = 200,
   parameter int TCONV = 665,
   parameter int SYNC_STAGES = 2,
   parameter int REG_DEPTH = 16
) (
   input logic clock_i,
   input logic reset_i,
   ads869x_if.slave bus
);
   localparam int TCONV_CYC = TCONV * CLOCK_FREQ / 1000;
   localparam int CW = $clog2(TCONV_CYC);
   localparam int IW = $clog2(REG_DEPTH);
   state_t state_q;
   logic [5:0] cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] rx_q, rx_d, tx_q, tx_load;
   logic [HWORD_BITS-1:0] regs_q [REG_DEPTH];
   logic [HWORD_BITS-1:0] rd_data_q, cur, new_val, wr_data_q;
   logic [DATA_BITS-1:0] conv_result_q, sample_q, src;
   logic [CW-1:0] conv_cnt_q;
   logic [SYNC_STAGES-1:0] sdi_q;
   logic [8:0] wr_addr_q;
   logic [6:0] op;
   logic [IW-1:0] ri;
   logic pending_q, rvs_q, wr_valid_q, done_q, err_q, perr_q;
   logic sclk_s, sclk_chg, conv_s, conv_chg, sclk_rise, conv_rise, conv_fall;
   logic shift_en, in_range, is_wr, conv_done;
   ads869x_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (.clock_i, .reset_i, .d_i(bus.sclk), .q_o(sclk_s), .chg_o(sclk_chg));
   ads869x_sync_edge #(.STAGES(SYNC_STAGES)) u_conv (.clock_i, .reset_i, .d_i(bus.conv), .q_o(conv_s), .chg_o(conv_chg));
   always_ff @(posedge clock_i)
      sdi_q <= reset_i ? '0 : {sdi_q[SYNC_STAGES-2:0], bus.sdi};
   // The SCLK edge is folded into cnt_d/rx_d so a coincident CONV rise sees the final bit.
   always_comb begin
      sclk_rise = sclk_chg & sclk_s;
      conv_rise = conv_chg & conv_s;
      conv_fall = conv_chg & ~conv_s;
      shift_en = state_q == ST_SHIFT && sclk_rise && cnt_q != 6'(FRAME_BITS);
      cnt_d = shift_en ? cnt_q + 6'd1 : cnt_q;
      rx_d = shift_en ? {rx_q[FRAME_BITS-2:0], sdi_q[SYNC_STAGES-1]} : rx_q;
      op = rx_d[31:25];
      in_range = 32'(rx_d[24:17]) < REG_DEPTH;
      ri = rx_d[17 +: IW];
      cur = in_range ? regs_q[ri] : '0;
      new_val = op == OP_CLEAR ? cur & ~rx_d[15:0] : op == OP_SET ? cur | rx_d[15:0] : rx_d[15:0];
      is_wr = in_range && (op == OP_CLEAR || op == OP_SET || op == OP_WRITE);
      tx_load = pending_q ? {rd_data_q, 16'h0} : {conv_result_q, 14'h0};
      conv_done = state_q == ST_CONVERTING && conv_cnt_q == CW'(TCONV_CYC - 1);
   end
`ifdef ADS869X_EMU_RAMP_EN
   logic [DATA_BITS-1:0] ramp_q;
   always_ff @(posedge clock_i)
      if (reset_i) ramp_q <= '0;
      else if (conv_done && !conv_fall) ramp_q <= ramp_q + 18'd1;
   assign src = regs_q[0][0] ? ramp_q : bus.sample_in;
`else
   assign src = bus.sample_in;
`endif
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         rx_q <= '0;
         tx_q <= '0;
         regs_q <= '{default: '0};
         rd_data_q <= '0;
         conv_result_q <= '0;
         sample_q <= '0;
         conv_cnt_q <= '0;
         pending_q <= 1'b0;
         rvs_q <= 1'b1;
         wr_valid_q <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         wr_valid_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (conv_fall) begin
               tx_q <= tx_load;
               pending_q <= 1'b0;
               cnt_q <= '0;
               state_q <= ST_SHIFT;
            end
            ST_SHIFT: begin
               cnt_q <= cnt_d;
               rx_q <= rx_d;
               if (shift_en) tx_q <= tx_q << 1;
               if (conv_rise && cnt_d == 6'(FRAME_BITS)) begin
                  state_q <= ST_DECODE;
                  if (op == OP_READ) begin
                     pending_q <= 1'b1;
                     rd_data_q <= cur;
                  end
                  if (is_wr) begin
                     regs_q[ri] <= new_val;
                     wr_valid_q <= 1'b1;
                     wr_addr_q <= rx_d[24:16];
                     wr_data_q <= new_val;
                  end
               end else if (conv_rise) begin
                  err_q <= 1'b1;
                  pending_q <= 1'b0;
                  sample_q <= src;
                  conv_cnt_q <= '0;
                  rvs_q <= 1'b0;
                  state_q <= ST_CONVERTING;
               end
            end
            ST_DECODE: begin
               done_q <= 1'b1;
               sample_q <= src;
               conv_cnt_q <= '0;
               rvs_q <= 1'b0;
               state_q <= ST_CONVERTING;
            end
            default: begin
               conv_cnt_q <= conv_cnt_q + CW'(1);
               if (conv_fall) begin
                  perr_q <= 1'b1;
                  rvs_q <= 1'b1;
                  tx_q <= tx_load;
                  pending_q <= 1'b0;
                  cnt_q <= '0;
                  state_q <= ST_SHIFT;
               end else if (conv_done) begin
                  conv_result_q <= sample_q;
                  rvs_q <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end
   assign bus.sdo = tx_q[FRAME_BITS-1];
   assign bus.rvs = rvs_q;
   assign bus.reg_wr_valid = wr_valid_q;
   assign bus.reg_wr_addr = wr_addr_q;
   assign bus.reg_wr_data = wr_data_q;
   assign bus.frame_done = done_q;
   assign bus.frame_error = err_q;
   assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_ads869x_spi_emulator.sv
// tb_ads869x_spi_emulator: host-side driver with a behavioural register/conversion model and directed plus random frames.
module tb_ads869x_spi_emulator;
   localparam logic [6:0] NOP = 7'b0000000;
   localparam logic [6:0] CLR = 7'b1100000;
   localparam logic [6:0] RD = 7'b1100100;
   localparam logic [6:0] WR = 7'b1101000;
   localparam logic [6:0] SET = 7'b1101100;
   localparam int TCONV_CYC = 665 * 200 / 1000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0, fails = 0;
   int wr_cnt = 0, done_cnt = 0, err_cnt = 0, low_run = 0, last_low = 0;
   logic [8:0] wr_addr;
   logic [15:0] wr_data;
   logic [31:0] rd;
   logic [15:0] m_regs [16];
   logic m_pend;
   logic [15:0] m_pdata;
   logic [17:0] m_conv;
   ads869x_if bus ();
   ads869x_spi_emulator dut (.clock_i(clk), .reset_i(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (bus.reg_wr_valid === 1'b1) begin
         wr_cnt++;
         wr_addr = bus.reg_wr_addr;
         wr_data = bus.reg_wr_data;
      end
      if (bus.frame_done === 1'b1) done_cnt++;
      if (bus.frame_error === 1'b1) err_cnt++;
      if (bus.rvs === 1'b0) low_run++;
      else begin
         if (low_run != 0) last_low = low_run;
         low_run = 0;
      end
   end
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic model_reset;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_pend = 1'b0;
      m_pdata = '0;
      m_conv = '0;
   endtask
   task automatic start_frame;
      bus.conv = 1'b0;
      cyc(6);
   endtask
   task automatic shift(input logic [31:0] w, input int n, input bit simul);
      rd = '0;
      for (int i = 0; i < n; i++) begin
         bus.sdi = w[31-i];
         cyc(5);
         rd = {rd[30:0], bus.sdo};
         bus.sclk = 1'b1;
         if (simul && i == n - 1) bus.conv = 1'b1;
         cyc(5);
         bus.sclk = 1'b0;
      end
      rd = rd << (32 - n);
   endtask
   task automatic end_frame;
      cyc(5);
      bus.conv = 1'b1;
   endtask
   task automatic settle;
      int k;
      cyc(10);
      k = 0;
      while (bus.rvs !== 1'b1 && k < 500) begin
         cyc(1);
         k++;
      end
      cyc(2);
      chk("rvs_ready", 32'(bus.rvs), 32'd1);
   endtask
   // Frame semantics from the host's point of view: readback, register effect, then a completed conversion.
   task automatic run(input logic [31:0] w, input int n, input bit simul);
      logic [31:0] er, mask;
      logic [15:0] v, nv;
      int idx, ew, w0, d0, e0;
      logic [6:0] op;
      er = m_pend ? {m_pdata, 16'h0} : {m_conv, 14'h0};
      m_pend = 1'b0;
      ew = 0;
      nv = '0;
      if (n == 32) begin
         op = w[31:25];
         idx = int'(w[24:16]) / 2;
         v = idx < 16 ? m_regs[idx] : 16'h0;
         if (op == WR) nv = w[15:0];
         else if (op == SET) nv = v | w[15:0];
         else if (op == CLR) nv = v & ~w[15:0];
         if (idx < 16 && (op == WR || op == SET || op == CLR)) begin
            m_regs[idx] = nv;
            ew = 1;
         end
         if (op == RD) begin
            m_pend = 1'b1;
            m_pdata = v;
         end
      end
      w0 = wr_cnt;
      d0 = done_cnt;
      e0 = err_cnt;
      start_frame;
      shift(w, n, simul);
      if (!simul) end_frame;
      settle;
      m_conv = bus.sample_in;
      mask = 32'hFFFF_FFFF << (32 - n);
      chk("sdo_readback", rd & mask, er & mask);
      chk("wr_pulses", 32'(wr_cnt - w0), 32'(ew));
      if (ew != 0) begin
         chk("wr_addr", 32'(wr_addr), 32'(w[24:16]));
         chk("wr_data", 32'(wr_data), 32'(nv));
      end
      chk("frame_done", 32'(done_cnt - d0), n == 32 ? 32'd1 : 32'd0);
      chk("frame_error", 32'(err_cnt - e0), n == 32 ? 32'd0 : 32'd1);
   endtask
   initial begin
      logic [6:0] op;
      logic [8:0] a;
      int k, n;
      bus.sclk = 1'b0;
      bus.conv = 1'b1;
      bus.sdi = 1'b0;
      bus.sample_in = '0;
      model_reset;
      cyc(4);
      chk("reset_sdo", 32'(bus.sdo), 32'd0);
      chk("reset_rvs", 32'(bus.rvs), 32'd1);
      chk("reset_perr", 32'(bus.protocol_err), 32'd0);
      chk("reset_wr_valid", 32'(bus.reg_wr_valid), 32'd0);
      rst = 1'b0;
      cyc(5);
      run({WR, 9'h010, 16'hA5A5}, 32, 0);
      chk("t1_wr_data", 32'(wr_data), 32'h0000_A5A5);
      run({RD, 9'h010, 16'h0000}, 32, 0);
      run({NOP, 9'h000, 16'h0000}, 32, 0);
      chk("t1_read_a5a5", 32'(rd[31:16]), 32'h0000_A5A5);
      bus.sample_in = 18'h2ABCD;
      run({NOP, 9'h000, 16'h0000}, 32, 0);
      chk("t2_rvs_low_cycles", 32'(last_low), 32'(TCONV_CYC));
      run({NOP, 9'h000, 16'h0000}, 32, 0);
      chk("t2_read_sample", 32'(rd[31:14]), 32'h0002_ABCD);
      run({SET, 9'h004, 16'h00F0}, 32, 0);
      chk("t3_set", 32'(wr_data), 32'h0000_00F0);
      run({CLR, 9'h004, 16'h0030}, 32, 0);
      chk("t3_clear", 32'(wr_data), 32'h0000_00C0);
      bus.sample_in = 18'h15555;
      run({WR, 9'h020, 16'hBEEF}, 20, 0);
      run({NOP, 9'h000, 16'h0000}, 32, 0);
      chk("t4_conv_after_abort", 32'(rd[31:14]), 32'h0001_5555);
      run({WR, 9'h006, 16'h1357}, 32, 1);
      chk("simul_edge_wr", 32'(wr_data), 32'h0000_1357);
      bus.sample_in = 18'h01234;
      run({NOP, 9'h000, 16'h0000}, 32, 0);
      bus.sample_in = 18'h3C3C5;
      start_frame;
      shift({NOP, 25'h0}, 32, 0);
      end_frame;
      cyc(14);
      chk("t5_rvs_busy", 32'(bus.rvs), 32'd0);
      bus.conv = 1'b0;
      cyc(6);
      chk("t5_perr_set", 32'(bus.protocol_err), 32'd1);
      chk("t5_rvs_released", 32'(bus.rvs), 32'd1);
      shift({NOP, 25'h0}, 32, 0);
      chk("t5_sdo_prev_result", rd, {18'h01234, 14'h0});
      end_frame;
      settle;
      m_conv = bus.sample_in;
      run({NOP, 9'h000, 16'h0000}, 32, 0);
      chk("t5_perr_sticky", 32'(bus.protocol_err), 32'd1);
      run({WR, 9'h1FE, 16'hFFFF}, 32, 0);
      run({RD, 9'h1FE, 16'h0000}, 32, 0);
      run({NOP, 9'h000, 16'h0000}, 32, 0);
      chk("t6_oor_read", 32'(rd[31:16]), 32'h0);
      run({RD, 9'h010, 16'h0000}, 32, 0);
      start_frame;
      shift({NOP, 25'h0}, 10, 0);
      cyc(3);
      chk("t6_pre_reset_sdo", 32'(bus.sdo), 32'(m_pdata[5]));
      rst = 1'b1;
      cyc(1);
      chk("t6_reset_sdo", 32'(bus.sdo), 32'd0);
      chk("t6_reset_rvs", 32'(bus.rvs), 32'd1);
      chk("t6_reset_perr", 32'(bus.protocol_err), 32'd0);
      bus.conv = 1'b1;
      cyc(3);
      rst = 1'b0;
      model_reset;
      cyc(5);
      run({RD, 9'h010, 16'h0000}, 32, 0);
      run({NOP, 9'h000, 16'h0000}, 32, 0);
      chk("t6_reg_cleared", 32'(rd[31:16]), 32'h0);
      for (int i = 0; i < 16; i++) begin
         k = $urandom_range(0, 5);
         op = k == 0 ? NOP : k == 1 ? CLR : k == 2 ? RD : k == 3 ? WR : k == 4 ? SET : 7'h55;
         a = $urandom_range(0, 3) == 0 ? 9'($urandom) : 9'($urandom_range(0, 31));
         n = $urandom_range(0, 7) == 0 ? int'($urandom_range(1, 31)) : 32;
         bus.sample_in = 18'($urandom);
         run({op, a, 16'($urandom)}, n, 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
